// File: rtl/axi4l_arbiter2_if.sv
// AXI4-Lite shared types and the bus interface used on both sides of the arbiter.
// The package comes first so the interface and the arbiter can import it.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi4l_if;
  import axi4l_pkg::*;
  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_arbiter2.sv
// Two-to-one AXI4-Lite arbiter: independent round-robin write and read FSMs,
// one outstanding transaction per channel, combinational payload muxes.
module axi4l_arbiter2
  import axi4l_pkg::*;
(
  input  logic    aclk,
  input  logic    aresetn,
  axi4l_if.slave  s0,
  axi4l_if.slave  s1,
  axi4l_if.master m
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

  // Round-robin pick: a lone requester wins, a tie goes to the one that did not win last.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    logic pick;
    if (req0 && req1) begin
      pick = ~last;
    end else begin
      pick = req1;
    end
    return pick;
  endfunction

  wstate_t wstate_r, wstate_s;
  rstate_t rstate_r, rstate_s;
  logic    wgnt_r, wgnt_s, wlast_r, wlast_s;
  logic    aw_done_r, aw_done_s, w_done_r, w_done_s;
  logic    rgnt_r, rgnt_s, rlast_r, rlast_s;

  logic    sel_awvalid_s, sel_wvalid_s, sel_bready_s, sel_arvalid_s, sel_rready_s;
  logic    aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

  assign sel_awvalid_s = wgnt_r ? s1.awvalid : s0.awvalid;
  assign sel_wvalid_s  = wgnt_r ? s1.wvalid  : s0.wvalid;
  assign sel_bready_s  = wgnt_r ? s1.bready  : s0.bready;
  assign sel_arvalid_s = rgnt_r ? s1.arvalid : s0.arvalid;
  assign sel_rready_s  = rgnt_r ? s1.rready  : s0.rready;

  assign aw_hs_s = (wstate_r == W_ADDR) & sel_awvalid_s & ~aw_done_r & m.awready;
  assign w_hs_s  = (wstate_r == W_ADDR) & sel_wvalid_s  & ~w_done_r  & m.wready;
  assign b_hs_s  = (wstate_r == W_RESP) & m.bvalid & sel_bready_s;
  assign ar_hs_s = (rstate_r == R_ADDR) & sel_arvalid_s & m.arready;
  assign r_hs_s  = (rstate_r == R_DATA) & m.rvalid & sel_rready_s;

  // Write FSM state, grant, last winner and per-channel completion flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_r  <= W_IDLE;
      wgnt_r    <= 1'b0;
      wlast_r   <= 1'b1;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      wstate_r  <= wstate_s;
      wgnt_r    <= wgnt_s;
      wlast_r   <= wlast_s;
      aw_done_r <= aw_done_s;
      w_done_r  <= w_done_s;
    end
  end

  // Write FSM next state: AW and W may complete in either order before the response
  always_comb begin
    wstate_s  = wstate_r;
    wgnt_s    = wgnt_r;
    wlast_s   = wlast_r;
    aw_done_s = aw_done_r;
    w_done_s  = w_done_r;
    case (wstate_r)
      W_IDLE: begin
        if (s0.awvalid || s1.awvalid) begin
          wgnt_s    = rr_pick(s0.awvalid, s1.awvalid, wlast_r);
          wlast_s   = wgnt_s;
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
          wstate_s  = W_ADDR;
        end else begin
          wstate_s  = W_IDLE;
        end
      end
      W_ADDR: begin
        aw_done_s = aw_done_r | aw_hs_s;
        w_done_s  = w_done_r | w_hs_s;
        if (aw_done_s && w_done_s) begin
          wstate_s = W_RESP;
        end else begin
          wstate_s = W_ADDR;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          wstate_s = W_IDLE;
        end else begin
          wstate_s = W_RESP;
        end
      end
      default: wstate_s = W_IDLE;
    endcase
  end

  // Write channel routing; payload always follows the grant, valids/readies only when active
  always_comb begin
    m.awaddr   = wgnt_r ? s1.awaddr : s0.awaddr;
    m.wdata    = wgnt_r ? s1.wdata  : s0.wdata;
    m.wstrb    = wgnt_r ? s1.wstrb  : s0.wstrb;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.bvalid  = 1'b0;
    s0.bresp   = RESP_OKAY;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.bvalid  = 1'b0;
    s1.bresp   = RESP_OKAY;
    case (wstate_r)
      W_ADDR: begin
        m.awvalid = sel_awvalid_s & ~aw_done_r;
        m.wvalid  = sel_wvalid_s & ~w_done_r;
        if (wgnt_r) begin
          s1.awready = m.awready & ~aw_done_r;
          s1.wready  = m.wready & ~w_done_r;
        end else begin
          s0.awready = m.awready & ~aw_done_r;
          s0.wready  = m.wready & ~w_done_r;
        end
      end
      W_RESP: begin
        m.bready = sel_bready_s;
        if (wgnt_r) begin
          s1.bvalid = m.bvalid;
          s1.bresp  = m.bresp;
        end else begin
          s0.bvalid = m.bvalid;
          s0.bresp  = m.bresp;
        end
      end
      default: m.bready = 1'b0;
    endcase
  end

  // Read FSM state, grant and last winner
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rstate_r <= R_IDLE;
      rgnt_r   <= 1'b0;
      rlast_r  <= 1'b1;
    end else begin
      rstate_r <= rstate_s;
      rgnt_r   <= rgnt_s;
      rlast_r  <= rlast_s;
    end
  end

  // Read FSM next state
  always_comb begin
    rstate_s = rstate_r;
    rgnt_s   = rgnt_r;
    rlast_s  = rlast_r;
    case (rstate_r)
      R_IDLE: begin
        if (s0.arvalid || s1.arvalid) begin
          rgnt_s   = rr_pick(s0.arvalid, s1.arvalid, rlast_r);
          rlast_s  = rgnt_s;
          rstate_s = R_ADDR;
        end else begin
          rstate_s = R_IDLE;
        end
      end
      R_ADDR: begin
        if (ar_hs_s) begin
          rstate_s = R_DATA;
        end else begin
          rstate_s = R_ADDR;
        end
      end
      R_DATA: begin
        if (r_hs_s) begin
          rstate_s = R_IDLE;
        end else begin
          rstate_s = R_DATA;
        end
      end
      default: rstate_s = R_IDLE;
    endcase
  end

  // Read channel routing; a non-granted master sees zero data and OKAY
  always_comb begin
    m.araddr   = rgnt_r ? s1.araddr : s0.araddr;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s0.rdata   = 32'h0000_0000;
    s0.rresp   = RESP_OKAY;
    s1.arready = 1'b0;
    s1.rvalid  = 1'b0;
    s1.rdata   = 32'h0000_0000;
    s1.rresp   = RESP_OKAY;
    case (rstate_r)
      R_ADDR: begin
        m.arvalid = sel_arvalid_s;
        if (rgnt_r) begin
          s1.arready = m.arready;
        end else begin
          s0.arready = m.arready;
        end
      end
      R_DATA: begin
        m.rready = sel_rready_s;
        if (rgnt_r) begin
          s1.rvalid = m.rvalid;
          s1.rdata  = m.rdata;
          s1.rresp  = m.rresp;
        end else begin
          s0.rvalid = m.rvalid;
          s0.rdata  = m.rdata;
          s0.rresp  = m.rresp;
        end
      end
      default: m.rready = 1'b0;
    endcase
  end

endmodule

// File: doc/axi4l_arbiter2.md
# axi4l_arbiter2

Two-to-one AXI4-Lite arbiter sharing a single slave (the on-chip dual-port RAM or a peripheral) between two masters, typically the Ibex instruction and data ports. Write and read channels are arbitrated independently, each by a round-robin FSM with one outstanding transaction per channel. Responses are routed back to the granted master. The arbiter sits between the core-side `axi4l_if` instances and the slave's `axi4l_if.slave` port.

## Interface
- No parameters. Address and data types come from `axi4l_pkg` (`addr_t`, 32-bit data, 4-bit strobe, 2-bit resp).
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s0`  `axi4l_if.slave`  bundle  requester 0 (wins the first tie after reset).
- `s1`  `axi4l_if.slave`  bundle  requester 1.
- `m`  `axi4l_if.master`  bundle  shared downstream slave.

## Operation
- **Write FSM** states: `W_IDLE`, `W_ADDR`, `W_RESP`. Grant register `wgnt` (0/1). Last-winner register `wlast`.
- **W_IDLE:**
  - Request i = `si.awvalid`.
  - One request: grant it.
  - Both requesting: grant `!wlast`.
  - On grant: `wgnt<=i`, `wlast<=i`, clear `aw_done`/`w_done`, go to `W_ADDR`.
- **W_ADDR:**
  - `m.aw*`/`m.w*` = granted master's signals, with valids masked by `!aw_done` / `!w_done`.
  - `s[g].awready = m.awready & !aw_done`; likewise for `wready`.
  - On each handshake, set the matching done flag.
  - When both handshakes have occurred, in the same or different cycles, go to `W_RESP`.
- **W_RESP:**
  - `s[g].bvalid = m.bvalid`, `s[g].bresp = m.bresp`, `m.bready = s[g].bready`.
  - On `m.bvalid & m.bready`, go to `W_IDLE`.
- **Read FSM** states: `R_IDLE`, `R_ADDR`, `R_DATA`, with `rgnt`/`rlast`, on the same round-robin rule. Request i = `si.arvalid`.
  - **R_ADDR:** forward AR. On `m.arvalid & m.arready`, go to `R_DATA`.
  - **R_DATA:** forward `rvalid`/`rdata`/`rresp` to the granted master and `rready` to `m`. On the R handshake, go to `R_IDLE`.
- Non-granted master, and every master while its FSM is idle:
  - `awready`/`wready`/`arready`/`bvalid`/`rvalid` = 0.
  - `rdata` = 0, `bresp`/`rresp` = `OKAY`.
- `m` valids are 0 outside `W_ADDR`/`R_ADDR`. `m.bready` is 0 outside `W_RESP`. `m.rready` is 0 outside `R_DATA`.
- Read and write channels never block each other. A read for s0 and a write for s1 may proceed concurrently.
- Masters must hold valid and payload stable until accepted (AXI rule). The arbiter does not register payload; payload paths are combinational muxes.
- **Reset** (`aresetn` low at a clock edge):
  - Both FSMs go to IDLE; `wlast = rlast = 1`, so s0 wins the first tie; done flags cleared.
  - All outputs take the idle values above on the following cycle.
  - Reset mid-transaction abandons it silently; the downstream slave must also be reset.

## Timing
- Arbitration latency 1 cycle: a request seen in IDLE at edge n drives `m.awvalid`/`m.arvalid` from cycle n+1.
- Against a zero-wait slave (ready tied 1, response one cycle after the address/data handshake):
  - Read: R handshake at cycle n+2, FSM back in `R_IDLE` at n+3. Read throughput 1 transaction per 3 cycles.
  - Write with AW and W presented together: same timing as read.
- Grant is never changed outside IDLE. A request withdrawn before grant is ignored; AXI forbids this anyway.
- Ready to a master is never asserted before that master's grant. There is no combinational path from `si.*valid` to `si.*ready` in IDLE.

## Test plan
- **Single read.** s0 reads 0x10 with a RAM holding 0xDEADBEEF there, s1 idle. Required: `s0.rvalid` with `rdata=0xDEADBEEF` 3 cycles after `arvalid`, `s1` sees nothing.
- **Read tie.** s0 and s1 `arvalid` in the same cycle, repeated 4 times back-to-back. Required: grants alternate s0, s1, s0, s1, each master gets its own data, and `rvalid` never reaches the wrong master.
- **Split write.** s1 asserts `awvalid` (addr 0x20) at cycle 0 and `wvalid` (data 0x12345678, `wstrb=4'b0011`) at cycle 3. Required: FSM holds in `W_ADDR` until W accepted, then `bvalid/OKAY` to s1, and a readback of 0x20 shows only the low 2 bytes updated.
- **Concurrent read and write.** s0 writes 0x4 while s1 reads 0x8 in the same cycle. Required: both complete in 3 cycles with no interaction.
- **Backpressure.** Hold `s0.rready=0` for 5 cycles. Required: FSM stays in `R_DATA` and `m.rready=0` throughout, and s1's read request is granted only after s0's R handshake.
- **Reset mid-write.** Pull `aresetn` low during `W_RESP`. Required: next cycle all valids/readies are 0, the FSM is in `W_IDLE`, and the first tie afterwards is granted to s0.
